// File: rtl/fofb_trig_pkg.sv
// Shared encodings and default widths for the FOFB trigger sequencer.
package fofb_trig_pkg;

    localparam int DLY_W_DEF = 16;
    localparam int CNT_W_DEF = 16;
    localparam int TMO_W_DEF = 24;
    localparam int MISS_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_FIRE  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/fofb_trig_sequencer_if.sv
// Control, trigger and status bundle between software/EVR logic and the sequencer.
interface fofb_trig_sequencer_if
    import fofb_trig_pkg::*;
#(
    parameter int DLY_W = DLY_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int TMO_W = TMO_W_DEF
);
    logic              arm;
    logic              abort;
    logic              evr_trig;
    logic              valid;
    logic [DLY_W-1:0]  delay;
    logic [CNT_W-1:0]  num_frames;
    logic [TMO_W-1:0]  timeout;
    logic              start_pulse;
    logic              done;
    logic              busy;
    logic              timeout_err;
    logic              aborted;
    logic [CNT_W-1:0]  frame_cnt;
    logic [MISS_W-1:0] miss_cnt;
    logic [2:0]        state_o;

    modport master (
        output arm, abort, evr_trig, valid, delay, num_frames, timeout,
        input  start_pulse, done, busy, timeout_err, aborted, frame_cnt, miss_cnt, state_o
    );

    modport slave (
        input  arm, abort, evr_trig, valid, delay, num_frames, timeout,
        output start_pulse, done, busy, timeout_err, aborted, frame_cnt, miss_cnt, state_o
    );
endinterface

// File: rtl/fofb_dn_counter.sv
// Loadable down-counter that parks at zero; load has priority over decrement.
module fofb_dn_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/fofb_trig_sequencer.sv
// Arms on software request, qualifies EVR triggers with BPM valid, delays and
// issues one start strobe per frame, with watchdog and missed-trigger accounting.
module fofb_trig_sequencer
    import fofb_trig_pkg::*;
#(
    parameter int DLY_W = DLY_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int TMO_W = TMO_W_DEF
) (
    input logic                 sysClk,
    input logic                 reset,
    fofb_trig_sequencer_if.slave bus
);
    state_e            state_q, state_d;
    logic [DLY_W-1:0]  delay_q, delay_d;
    logic [CNT_W-1:0]  num_frames_q, num_frames_d;
    logic [TMO_W-1:0]  timeout_q, timeout_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic              aborted_q, aborted_d;

    logic              miss_inc, miss_clr;
    logic              dly_load, dly_en, dly_zero;
    logic              wd_load, wd_en, wd_zero;
    logic [TMO_W-1:0]  wd_load_val;

    always_comb begin
        state_d       = state_q;
        delay_d       = delay_q;
        num_frames_d  = num_frames_q;
        timeout_d     = timeout_q;
        frame_cnt_d   = frame_cnt_q;
        timeout_err_d = timeout_err_q;
        aborted_d     = aborted_q;
        miss_inc      = 1'b0;
        miss_clr      = 1'b0;
        dly_load      = 1'b0;
        dly_en        = 1'b0;
        wd_load       = 1'b0;
        wd_en         = 1'b0;
        // Watchdog holds T-1 so that its zero flag marks the T-th ARMED cycle
        wd_load_val   = timeout_q - 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.arm) begin
                    delay_d       = bus.delay;
                    num_frames_d  = bus.num_frames;
                    timeout_d     = bus.timeout;
                    frame_cnt_d   = '0;
                    miss_clr      = 1'b1;
                    timeout_err_d = 1'b0;
                    aborted_d     = 1'b0;
                    wd_load       = 1'b1;
                    wd_load_val   = bus.timeout - 1'b1;
                    state_d       = ST_ARMED;
                end
            end
            ST_ARMED: begin
                wd_en    = (timeout_q != '0);
                miss_inc = bus.evr_trig && !bus.valid;
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if ((timeout_q != '0) && wd_zero) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else if (bus.evr_trig && bus.valid) begin
                    dly_load = 1'b1;
                    state_d  = ST_DELAY;
                end
            end
            ST_DELAY: begin
                dly_en   = 1'b1;
                miss_inc = bus.evr_trig;
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (dly_zero) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                miss_inc    = bus.evr_trig;
                frame_cnt_d = frame_cnt_q + 1'b1;
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if ((num_frames_q == '0) || (frame_cnt_d < num_frames_q)) begin
                    wd_load = 1'b1;
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        miss_cnt_d = miss_cnt_q;
        if (miss_clr) begin
            miss_cnt_d = '0;
        end else if (miss_inc && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sysClk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            delay_q       <= '0;
            num_frames_q  <= '0;
            timeout_q     <= '0;
            frame_cnt_q   <= '0;
            miss_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            delay_q       <= delay_d;
            num_frames_q  <= num_frames_d;
            timeout_q     <= timeout_d;
            frame_cnt_q   <= frame_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            timeout_err_q <= timeout_err_d;
            aborted_q     <= aborted_d;
        end
    end

    fofb_dn_counter #(.W(DLY_W)) u_dly_cnt (
        .clk      (sysClk),
        .rst      (reset),
        .load     (dly_load),
        .en       (dly_en),
        .load_val (delay_q),
        .zero     (dly_zero)
    );

    fofb_dn_counter #(.W(TMO_W)) u_wd_cnt (
        .clk      (sysClk),
        .rst      (reset),
        .load     (wd_load),
        .en       (wd_en),
        .load_val (wd_load_val),
        .zero     (wd_zero)
    );

    // Strobes decode straight from the state register, so they stay registered
    assign bus.start_pulse = (state_q == ST_FIRE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.timeout_err = timeout_err_q;
    assign bus.aborted     = aborted_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.miss_cnt    = miss_cnt_q;
    assign bus.state_o     = state_q;
endmodule
